// File: rtl/seven_seg_pkg.sv
// Shared constants, FSM encoding and anode decode for the seven-segment scan controller.
// Pure declarations: no latency, no flow control.
package seven_seg_pkg;

  localparam logic [1:0] DIG_ONES     = 2'd0;
  localparam logic [1:0] DIG_TENS     = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;
  localparam logic [1:0] DIG_LETTERS  = 2'd3;

  localparam logic [3:0] AN_ALL_OFF = 4'b1111;

  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  // Active-low one-cold anode pattern for a digit index.
  function automatic logic [3:0] an_decode(input logic [1:0] sel);
    logic [3:0] an;
    an = AN_ALL_OFF;
    case (sel)
      DIG_ONES:     an = 4'b1110;
      DIG_TENS:     an = 4'b1101;
      DIG_HUNDREDS: an = 4'b1011;
      DIG_LETTERS:  an = 4'b0111;
      default:      an = AN_ALL_OFF;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Divide-by-DIV prescaler: terminal is high in the last count cycle (DIV-1) while enabled.
// Latency: one terminal every DIV enabled clocks; enable=0 freezes the count, no other backpressure.
module refresh_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_chk
    $error("refresh_prescaler: DIV must be >= 2");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_end;

  assign w_at_end = (r_cnt == CNT_W'(DIV - 1));
  assign terminal = enable & w_at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_at_end ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit scan controller: AN_SEL/AN/scan_tick/frame_done all registered, updated on the same edge.
// No backpressure; enable=0 freezes scan and blanks. Optional SCAN_BLANK_EN adds anode dead-time.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] digit_mask,
  output logic [1:0] AN_SEL,
  output logic [3:0] AN,
  output logic       scan_tick,
  output logic       frame_done
);

  localparam int DIV = CLK_FREQ_HZ / REFRESH_HZ;

  if (DIV < 2) begin : g_div_chk
    $error("seven_seg_scan_ctrl: CLK_FREQ_HZ/REFRESH_HZ must be >= 2");
  end
  if (BLANK_CYCLES >= DIV) begin : g_blank_chk
    $error("seven_seg_scan_ctrl: BLANK_CYCLES must be < DIV");
  end

  logic [1:0]  r_an_sel;
  logic [3:0]  r_an;
  logic        r_scan_tick;
  logic        r_frame_done;
  scan_state_t r_state;

  logic        w_terminal;
  logic [1:0]  w_an_sel_nxt;
  logic [3:0]  w_an_nxt;
  scan_state_t w_state_nxt;

  refresh_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .terminal(w_terminal)
  );

`ifdef SCAN_BLANK_EN
  localparam int BCNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1;

  if (BLANK_CYCLES < 1) begin : g_blank_min_chk
    $error("seven_seg_scan_ctrl: BLANK_CYCLES must be >= 1 with blanking enabled");
  end

  logic [BCNT_W-1:0] r_bcnt;
  logic [BCNT_W-1:0] w_bcnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt <= '0;
    end else begin
      r_bcnt <= w_bcnt_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_an_sel_nxt = r_an_sel;
`ifdef SCAN_BLANK_EN
    w_bcnt_nxt   = r_bcnt;
`endif
    if (w_terminal) begin
      w_an_sel_nxt = r_an_sel + 2'd1;
    end

`ifdef SCAN_BLANK_EN
    // Dead-time runs inside the DIV period; it only advances on enabled clocks.
    case (r_state)
      SCAN: begin
        if (w_terminal) begin
          w_state_nxt = BLANK;
          w_bcnt_nxt  = '0;
        end
      end
      BLANK: begin
        if (enable) begin
          if (r_bcnt == BCNT_W'(BLANK_CYCLES - 1)) begin
            w_state_nxt = SCAN;
          end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = SCAN;
    endcase
`else
    w_state_nxt = SCAN;
`endif

    // Decode from next-state values so AN and AN_SEL land on the same edge.
    w_an_nxt = AN_ALL_OFF;
    if (enable && (w_state_nxt == SCAN)) begin
      w_an_nxt = an_decode(w_an_sel_nxt) | digit_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= SCAN;
      r_an_sel     <= DIG_ONES;
      r_an         <= AN_ALL_OFF;
      r_scan_tick  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_an_sel     <= w_an_sel_nxt;
      r_an         <= w_an_nxt;
      r_scan_tick  <= w_terminal;
      r_frame_done <= w_terminal && (r_an_sel == DIG_LETTERS);
    end
  end

  assign AN_SEL     = r_an_sel;
  assign AN         = r_an;
  assign scan_tick  = r_scan_tick;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: model tracks enabled clocks since reset and derives every output arithmetically.
module tb_seven_seg_scan_ctrl;

`ifdef SCAN_BLANK_EN
  localparam int  CLK_HZ  = 80;
  localparam int  REF_HZ  = 10;
  localparam int  BLANK   = 2;
  localparam bit  BLANKON = 1'b1;
`else
  localparam int  CLK_HZ  = 40;
  localparam int  REF_HZ  = 10;
  localparam int  BLANK   = 2;
  localparam bit  BLANKON = 1'b0;
`endif
  localparam int DIV = CLK_HZ / REF_HZ;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] digit_mask;
  logic [1:0] AN_SEL;
  logic [3:0] AN;
  logic       scan_tick;
  logic       frame_done;

  int n_cmp;
  int n_fail;
  int p;          // enabled clock edges since reset release
  logic [3:0] exp_an;
  logic [1:0] exp_sel;
  logic       exp_tick;
  logic       exp_frame;

  seven_seg_scan_ctrl #(
    .CLK_FREQ_HZ (CLK_HZ),
    .REFRESH_HZ  (REF_HZ),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .digit_mask(digit_mask),
    .AN_SEL    (AN_SEL),
    .AN        (AN),
    .scan_tick (scan_tick),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".AN_SEL"}, {2'b00, AN_SEL}, {2'b00, exp_sel});
    check({tag, ".AN"}, AN, exp_an);
    check({tag, ".scan_tick"}, {3'b000, scan_tick}, {3'b000, exp_tick});
    check({tag, ".frame_done"}, {3'b000, frame_done}, {3'b000, exp_frame});
  endtask

  // One clock: fold the inputs seen at the edge into the model, then compare 1ns later.
  task automatic step(input string tag);
    int d;
    logic blanked;
    @(posedge clk);
    if (enable) p++;
    d         = (p / DIV) % 4;
    exp_sel   = d[1:0];
    exp_tick  = enable && (p > 0) && (p % DIV == 0);
    exp_frame = exp_tick && (d == 0);
    blanked   = BLANKON && (p >= DIV) && ((p % DIV) < BLANK);
    exp_an    = 4'b1111;
    if (enable && !blanked && !digit_mask[d]) exp_an[d] = 1'b0;
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    p          = 0;
    rst_n      = 1'b0;
    enable     = 1'b1;
    digit_mask = 4'b0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    exp_sel = 2'b00; exp_an = 4'b1111; exp_tick = 1'b0; exp_frame = 1'b0;
    check_all("reset");
    rst_n = 1'b1;

    // Free run and framing pulses
    run("freerun", 4 * DIV + 4);

    // Masking, then full mask mid-digit
    digit_mask = 4'b0100;
    run("mask0100", 4 * DIV);
    for (int i = 0; i < 4 * DIV && (p % DIV) != 1; i++) step("align");
    digit_mask = 4'b1111;
    run("mask1111", 2 * DIV);
    digit_mask = 4'b0000;

    // Enable freeze at digit 1, count 2
    for (int i = 0; i < 8 * DIV && !(((p / DIV) % 4) == 1 && (p % DIV) == 2); i++)
      step("seek_freeze");
    check("freeze_pos", p[3:0] % 4'(DIV), 4'd2);
    enable = 1'b0;
    run("frozen", 10);
    enable = 1'b1;
    run("resume", DIV + 2);

    // Asynchronous reset mid-scan at digit 3
    for (int i = 0; i < 8 * DIV && ((p / DIV) % 4) != 3; i++) step("seek_rst");
    #2;
    rst_n = 1'b0;
    #1;
    p = 0;
    exp_sel = 2'b00; exp_an = 4'b1111; exp_tick = 1'b0; exp_frame = 1'b0;
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
    run("post_rst", 2 * DIV + 1);

    // Randomised enable and mask traffic
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) digit_mask = 4'($urandom_range(0, 15));
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
